// File: rtl/rptr_empty_if.sv
// Read-side bundle between the FIFO read-pointer controller and its user/RAM.
// The master drives the write pointer, read request and configuration; the slave reports pointers and flags.
interface rptr_empty_if #(
  parameter int ASIZE = 4
);
  logic [ASIZE:0]   wptr_gray;
  logic             rinc;
  logic [ASIZE:0]   ae_thresh;
  logic             underflow_clr;
  logic [ASIZE-1:0] raddr;
  logic [ASIZE:0]   rptr;
  logic             rempty;
  logic             ralmost_empty;
  logic [ASIZE:0]   rlevel;
  logic             runderflow;

  modport master (
    output wptr_gray, rinc, ae_thresh, underflow_clr,
    input  raddr, rptr, rempty, ralmost_empty, rlevel, runderflow
  );

  modport slave (
    input  wptr_gray, rinc, ae_thresh, underflow_clr,
    output raddr, rptr, rempty, ralmost_empty, rlevel, runderflow
  );
endinterface

// File: rtl/rptr_empty_ctrl.sv
// Read-domain pointer and flag controller for the asynchronous line FIFO.
// Synchronises the write Gray pointer and produces read address, Gray pointer, level and status flags.
module rptr_empty_ctrl #(
  parameter int ASIZE       = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic        rclk,
  input logic        rrst,
  rptr_empty_if.slave bus
);
  localparam int W = ASIZE + 1;

  logic [W-1:0] sync_q [SYNC_STAGES];
  logic [W-1:0] rq_wptr;
  logic [W-1:0] rq_wbin;
  logic [W-1:0] rbin;
  logic [W-1:0] rbinnext;
  logic [W-1:0] rgraynext;
  logic [W-1:0] level_next;
  logic [W-1:0] rptr_q;
  logic [W-1:0] rlevel_q;
  logic         rempty_q;
  logic         ralmost_q;
  logic         runder_q;
  logic         rd_en;

  // XOR-prefix from the MSB down: each binary bit folds in every Gray bit above it.
  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Synchroniser stage boundary: only the first flop ever sees the asynchronous pointer.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= bus.wptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign rq_wptr = sync_q[SYNC_STAGES-1];
  assign rq_wbin = gray2bin(rq_wptr);

  always_comb begin
    rd_en      = bus.rinc & ~rempty_q;
    rbinnext   = rbin + {{ASIZE{1'b0}}, rd_en};
    rgraynext  = (rbinnext >> 1) ^ rbinnext;
    level_next = rq_wbin - rbinnext;
  end

  // Pointer/flag register boundary: flags use next-state pointers so a read never sees stale data.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin      <= '0;
      rptr_q    <= '0;
      rlevel_q  <= '0;
      rempty_q  <= 1'b1;
      ralmost_q <= 1'b1;
      runder_q  <= 1'b0;
    end else begin
      rbin      <= rbinnext;
      rptr_q    <= rgraynext;
      rlevel_q  <= level_next;
      rempty_q  <= (rgraynext == rq_wptr);
      ralmost_q <= (level_next <= bus.ae_thresh);
      if (bus.rinc && rempty_q) runder_q <= 1'b1;
      else if (bus.underflow_clr) runder_q <= 1'b0;
    end
  end

  assign bus.raddr         = rbin[ASIZE-1:0];
  assign bus.rptr          = rptr_q;
  assign bus.rempty        = rempty_q;
  assign bus.ralmost_empty = ralmost_q;
  assign bus.rlevel        = rlevel_q;
  assign bus.runderflow    = runder_q;
endmodule
